// File: rtl/pool_layer.sv
// Max/average pooling stage: snapshots a full feature map on start, then scans
// non-overlapping POOL_SIZE x POOL_SIZE windows at one output pixel per clock.
module pool_layer #(
  parameter int    FMROW      = 30,
  parameter int    FMCOL      = 30,
  parameter int    DATA_WIDTH = 8,
  parameter int    POOL_SIZE  = 2,
  parameter string POOL_TYPE  = "MAX"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] feature_map [0:FMROW-1][0:FMCOL-1],
  output logic [DATA_WIDTH-1:0] pool_out [0:FMROW/POOL_SIZE-1][0:FMCOL/POOL_SIZE-1],
  output logic                  busy,
  output logic                  pool_done
);

  localparam int OUTROW   = FMROW / POOL_SIZE;
  localparam int OUTCOL   = FMCOL / POOL_SIZE;
  localparam int WIN      = POOL_SIZE * POOL_SIZE;
  localparam int SUM_W    = DATA_WIDTH + $clog2(WIN);
  localparam int SHIFT    = $clog2(WIN);
  localparam bit WIN_POW2 = ((WIN & (WIN - 1)) == 0);
  localparam bit IS_AVG   = (POOL_TYPE == "AVG");
  localparam int RC_W     = (OUTROW > 1) ? $clog2(OUTROW) : 1;
  localparam int CC_W     = (OUTCOL > 1) ? $clog2(OUTCOL) : 1;
  localparam int FR_W     = (FMROW > 1) ? $clog2(FMROW) : 1;
  localparam int FC_W     = (FMCOL > 1) ? $clog2(FMCOL) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                  state;
  logic [RC_W-1:0]         r_cnt;
  logic [CC_W-1:0]         c_cnt;
  logic [DATA_WIDTH-1:0]   snapshot [0:FMROW-1][0:FMCOL-1];

  logic [DATA_WIDTH-1:0]   px;
  logic [DATA_WIDTH-1:0]   win_max;
  logic [SUM_W-1:0]        win_sum;
  logic [DATA_WIDTH-1:0]   win_res;

  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   res_p1;
  logic [RC_W-1:0]         ridx_p1;
  logic [CC_W-1:0]         cidx_p1;

  // Truncating average; the sum of WIN pixels divided by WIN always fits DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] avg_div(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] q;
    if (WIN_POW2) q = s >> SHIFT;
    else          q = s / SUM_W'(WIN);
    return q[DATA_WIDTH-1:0];
  endfunction

  // Stage 0: combinational window reduction addressed by the scan counters
  always_comb begin
    px      = '0;
    win_max = '0;
    win_sum = '0;
    for (int i = 0; i < POOL_SIZE; i++) begin
      for (int j = 0; j < POOL_SIZE; j++) begin
        px = snapshot[FR_W'(int'(r_cnt) * POOL_SIZE + i)]
                     [FC_W'(int'(c_cnt) * POOL_SIZE + j)];
        if (px > win_max) win_max = px;
        win_sum = win_sum + SUM_W'(px);
      end
    end
    win_res = IS_AVG ? avg_div(win_sum) : win_max;
  end

  // Stage 1: registered window result with its output coordinate
  always_ff @(posedge clk) begin
    res_p1  <= win_res;
    ridx_p1 <= r_cnt;
    cidx_p1 <= c_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r_cnt     <= '0;
      c_cnt     <= '0;
      busy      <= 1'b0;
      pool_done <= 1'b0;
      vld_p1    <= 1'b0;
      snapshot  <= '{default: '0};
      pool_out  <= '{default: '0};
    end else begin
      pool_done <= 1'b0;
      vld_p1    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= feature_map;
            r_cnt    <= '0;
            c_cnt    <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          vld_p1 <= 1'b1;
          if (c_cnt == CC_W'(OUTCOL - 1)) begin
            c_cnt <= '0;
            if (r_cnt == RC_W'(OUTROW - 1)) state <= DRAIN;
            else                            r_cnt <= r_cnt + 1'b1;
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
        DRAIN: begin
          busy      <= 1'b0;
          pool_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Stage 2: write-back into the held output map
      if (vld_p1) pool_out[ridx_p1][cidx_p1] <= res_p1;
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
// Scoreboard bench for pool_layer: four configurations (30x30 MAX, 6x6 AVG,
// 7x7 AVG with divide, 5x5 MAX with remainder) checked against a window model.
module tb_pool_layer;

  logic clk, rst;
  logic st0, st1, st2, st3;
  logic bz0, bz1, bz2, bz3;
  logic dn0, dn1, dn2, dn3;
  logic [7:0] fm0 [0:29][0:29];
  logic [7:0] po0 [0:14][0:14];
  logic [7:0] fm1 [0:5][0:5];
  logic [7:0] po1 [0:2][0:2];
  logic [7:0] fm2 [0:6][0:6];
  logic [7:0] po2 [0:1][0:1];
  logic [7:0] fm3 [0:4][0:4];
  logic [7:0] po3 [0:1][0:1];

  pool_layer #(.FMROW(30), .FMCOL(30), .DATA_WIDTH(8), .POOL_SIZE(2), .POOL_TYPE("MAX"))
    dut0 (.clk(clk), .rst(rst), .start(st0), .feature_map(fm0), .pool_out(po0), .busy(bz0), .pool_done(dn0));
  pool_layer #(.FMROW(6), .FMCOL(6), .DATA_WIDTH(8), .POOL_SIZE(2), .POOL_TYPE("AVG"))
    dut1 (.clk(clk), .rst(rst), .start(st1), .feature_map(fm1), .pool_out(po1), .busy(bz1), .pool_done(dn1));
  pool_layer #(.FMROW(7), .FMCOL(7), .DATA_WIDTH(8), .POOL_SIZE(3), .POOL_TYPE("AVG"))
    dut2 (.clk(clk), .rst(rst), .start(st2), .feature_map(fm2), .pool_out(po2), .busy(bz2), .pool_done(dn2));
  pool_layer #(.FMROW(5), .FMCOL(5), .DATA_WIDTH(8), .POOL_SIZE(2), .POOL_TYPE("MAX"))
    dut3 (.clk(clk), .rst(rst), .start(st3), .feature_map(fm3), .pool_out(po3), .busy(bz3), .pool_done(dn3));

  int rows [4], cols [4], ps [4], npix [4], e0 [4];
  bit avg [4], act [4];
  int mdl [4][$];
  int exp_px [4][$];
  int held [4][$];
  int cyc = 0;
  int n_vec = 0, n_bad = 0;
  bit mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int d, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", nm, d, cyc, got, exp);
    end
  endfunction

  function automatic logic get_bz(int d);
    case (d) 0: return bz0; 1: return bz1; 2: return bz2; default: return bz3; endcase
  endfunction

  function automatic logic get_dn(int d);
    case (d) 0: return dn0; 1: return dn1; 2: return dn2; default: return dn3; endcase
  endfunction

  function automatic void set_st(int d, logic v);
    case (d) 0: st0 = v; 1: st1 = v; 2: st2 = v; default: st3 = v; endcase
  endfunction

  function automatic void flat(input int d, output logic [31:0] q [$]);
    q.delete();
    for (int i = 0; i < rows[d] / ps[d]; i++)
      for (int j = 0; j < cols[d] / ps[d]; j++)
        case (d)
          0: q.push_back(32'(po0[i][j]));
          1: q.push_back(32'(po1[i][j]));
          2: q.push_back(32'(po2[i][j]));
          default: q.push_back(32'(po3[i][j]));
        endcase
  endfunction

  function automatic void apply_map(int d);
    for (int i = 0; i < rows[d]; i++)
      for (int j = 0; j < cols[d]; j++)
        case (d)
          0: fm0[i][j] = 8'(mdl[0][i*cols[0]+j]);
          1: fm1[i][j] = 8'(mdl[1][i*cols[1]+j]);
          2: fm2[i][j] = 8'(mdl[2][i*cols[2]+j]);
          default: fm3[i][j] = 8'(mdl[3][i*cols[3]+j]);
        endcase
  endfunction

  // mode 0: constant v, 1: random, 2: ramp (i*30+j) mod 256
  function automatic void fill(int d, int mode, int v);
    mdl[d].delete();
    for (int k = 0; k < rows[d] * cols[d]; k++)
      case (mode)
        0: mdl[d].push_back(v);
        1: mdl[d].push_back(int'($urandom_range(0, 255)));
        default: mdl[d].push_back(((k / cols[d]) * 30 + (k % cols[d])) % 256);
      endcase
    apply_map(d);
  endfunction

  // Reference: floor-sized grid of windows, max or truncated mean of each.
  function automatic void push_expect(int d);
    for (int r = 0; r < rows[d] / ps[d]; r++)
      for (int c = 0; c < cols[d] / ps[d]; c++) begin
        int mx = 0, s = 0, v;
        for (int i = 0; i < ps[d]; i++)
          for (int j = 0; j < ps[d]; j++) begin
            v = mdl[d][(r*ps[d]+i)*cols[d] + c*ps[d]+j];
            if (v > mx) mx = v;
            s += v;
          end
        exp_px[d].push_back(avg[d] ? s / (ps[d]*ps[d]) : mx);
      end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 4; d++) begin
      act[d] = 0;
      exp_px[d].delete();
      held[d].delete();
      for (int k = 0; k < npix[d]; k++) held[d].push_back(0);
    end
  endfunction

  // Monitor: per-cycle busy/done timing, result pop on pool_done, held-map check outside runs.
  function automatic void check_dut(int d);
    logic [31:0] got [$];
    int  lastw = e0[d] + npix[d];
    bit  inrun = act[d] && cyc >= e0[d] && cyc <= lastw;
    bit  edone = act[d] && cyc == lastw + 1;
    bit  bad = 0;
    chk("busy", d, 32'(get_bz(d)), 32'(inrun));
    chk("pool_done", d, 32'(get_dn(d)), 32'(edone));
    if (edone && exp_px[d].size() >= npix[d]) begin
      held[d].delete();
      for (int k = 0; k < npix[d]; k++) held[d].push_back(exp_px[d].pop_front());
    end
    if (!inrun) begin
      flat(d, got);
      n_vec++;
      for (int k = 0; k < npix[d] && !bad; k++)
        if (got[k] !== 32'(held[d][k])) begin
          bad = 1;
          n_bad++;
          $display("FAIL pool_out dut%0d cyc %0d pixel %0d: got %0d, expected %0d",
                   d, cyc, k, got[k], held[d][k]);
        end
    end
  endfunction

  always @(negedge clk) if (mon_en) for (int d = 0; d < 4; d++) check_dut(d);

  task automatic tick(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_start(int d);
    bit accepted = !act[d] || (cyc + 1 >= e0[d] + npix[d] + 2);
    set_st(d, 1'b1);
    if (accepted) begin
      push_expect(d);
      e0[d]  = cyc + 1;
      act[d] = 1;
    end
    tick(1);
    set_st(d, 1'b0);
  endtask

  task automatic wait_done(int d, int budget);
    int k = 0;
    while (get_dn(d) !== 1'b1 && k < budget) begin tick(1); k++; end
    if (get_dn(d) !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout dut%0d: pool_done not seen within %0d cycles", d, budget);
    end
  endtask

  initial begin
    rows = '{30, 6, 7, 5};
    cols = '{30, 6, 7, 5};
    ps   = '{2, 2, 3, 2};
    avg  = '{0, 1, 1, 0};
    for (int d = 0; d < 4; d++) begin
      npix[d] = (rows[d] / ps[d]) * (cols[d] / ps[d]);
      e0[d] = 0;
      fill(d, 1, 0);
    end
    rst = 1'b1;
    st0 = 0; st1 = 0; st2 = 0; st3 = 0;
    tick(2);
    rst = 1'b0;
    model_reset();
    mon_en = 1;
    tick(500);

    // MAX on the ramp map
    fill(0, 2, 0);
    do_start(0);
    wait_done(0, 300);
    tick(3);

    // AVG truncation windows {1,2,2,2}, {255 x4}, {0,0,0,3}
    fill(1, 1, 0);
    mdl[1][0] = 1;   mdl[1][1] = 2;   mdl[1][6] = 2;   mdl[1][7] = 2;
    mdl[1][2] = 255; mdl[1][3] = 255; mdl[1][8] = 255; mdl[1][9] = 255;
    mdl[1][4] = 0;   mdl[1][5] = 0;   mdl[1][10] = 0;  mdl[1][11] = 3;
    apply_map(1);
    do_start(1);
    wait_done(1, 40);
    chk("avg_1222", 1, 32'(po1[0][0]), 1);
    chk("avg_255", 1, 32'(po1[0][1]), 255);
    chk("avg_0003", 1, 32'(po1[0][2]), 0);
    tick(2);

    // Random runs on the small configurations, overlapping in time
    for (int it = 0; it < 4; it++) begin
      for (int d = 1; d < 4; d++) begin
        fill(d, 1, 0);
        do_start(d);
      end
      tick(20);
    end

    // Snapshot isolation
    fill(0, 0, 5);
    do_start(0);
    fill(0, 0, 200);
    wait_done(0, 300);
    tick(2);

    // Ignored start mid-run, then a start in the pool_done cycle
    fill(0, 1, 0);
    do_start(0);
    while (cyc < e0[0] + 49) tick(1);
    fill(0, 1, 0);
    do_start(0);
    wait_done(0, 300);
    fill(0, 0, 9);
    do_start(0);
    wait_done(0, 300);
    tick(2);

    // Mid-run reset
    fill(0, 1, 0);
    do_start(0);
    while (cyc < e0[0] + 99) tick(1);
    rst = 1'b1;
    model_reset();
    tick(1);
    rst = 1'b0;
    tick(300);

    // Odd size with discarded row/col
    fill(3, 1, 0);
    do_start(3);
    wait_done(3, 20);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
